// File: rtl/spectrum_frame_ctrl.sv
// spectrum_frame_ctrl: triggered sample capture, AXIS feed to an FFT core and
// scaled per-bin power readout. Define SPECTRUM_AVG_EN for per-bin averaging.
module spectrum_frame_ctrl #(
    parameter int LOG2_N   = 10,
    parameter int SAMPLE_W = 8,
    parameter int FFT_W    = 24,
    parameter int POW_SH   = 23
) (
    input  logic                  ckaTime,
    input  logic                  btnL,
    input  logic                  flgStartAcquisition,
    input  logic                  smpValid,
    input  logic [SAMPLE_W-1:0]   smpData,
    input  logic [1:0]            trigMode,
    input  logic [SAMPLE_W-1:0]   trigLevel,
    input  logic [2:0]            shiftSel,
    output logic [2*SAMPLE_W-1:0] s_axis_data_tdata,
    output logic                  s_axis_data_tvalid,
    output logic                  s_axis_data_tlast,
    input  logic                  s_axis_data_tready,
    input  logic [2*FFT_W-1:0]    m_axis_data_tdata,
    input  logic                  m_axis_data_tvalid,
    input  logic                  m_axis_data_tlast,
    output logic                  m_axis_data_tready,
    output logic [LOG2_N-1:0]     addrFreq,
    output logic [7:0]            byteFreqSample,
    output logic                  flgFreqSampleValid,
    output logic                  flgBusy,
    output logic                  flgFrameErr
);
    localparam int N  = 1 << LOG2_N;
    localparam int PW = 2 * FFT_W + 1;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, LOAD, UNLOAD} state_t;

    state_t                     state_q, state_d;
    logic [LOG2_N-1:0]          cnt_q, cnt_d;
    logic [1:0]                 mode_q, mode_d;
    logic signed [SAMPLE_W-1:0] lvl_q, lvl_d;
    logic signed [SAMPLE_W-1:0] prev_q, prev_d;
    logic                       prev_vld_q, prev_vld_d;
    logic                       s_vld_q, s_vld_d;
    logic                       s_last_q, s_last_d;
    logic [SAMPLE_W-1:0]        s_dat_q, s_dat_d;
    logic                       fv_q, fv_d;
    logic [LOG2_N-1:0]          addr_q, addr_d;
    logic [7:0]                 byte_q, byte_d;
    logic                       err_q, err_d;

    logic [SAMPLE_W-1:0]        smp_mem [N];
    logic                       mem_we;
    logic [LOG2_N-1:0]          mem_wa;
    logic [LOG2_N-1:0]          cnt_inc;

    logic signed [SAMPLE_W-1:0] cur;
    logic                       trig_hit;

    logic signed [FFT_W-1:0]    fft_re, fft_im;
    logic signed [2*FFT_W-1:0]  re_sq, im_sq;
    logic [PW-1:0]              pow, pow_sh;
    logic [7:0]                 sh_amt, sat;
    logic [7:0]                 bin_val;
    logic                       beat;

    assign cnt_inc = cnt_q + 1'b1;
    assign beat    = (state_q == UNLOAD) && m_axis_data_tvalid;

    // Trigger condition for the current sample against the latched config.
    always_comb begin
        cur = $signed(smpData);
        unique case (mode_q)
            2'b00:   trig_hit = 1'b1;
            2'b01:   trig_hit = prev_vld_q && (prev_q < lvl_q) && (cur >= lvl_q);
            2'b10:   trig_hit = prev_vld_q && (prev_q >= lvl_q) && (cur < lvl_q);
            default: trig_hit = (cur >= lvl_q);
        endcase
    end

    // Full-precision bin power, variable slice and saturation to one byte.
    always_comb begin
        fft_re = $signed(m_axis_data_tdata[FFT_W-1:0]);
        fft_im = $signed(m_axis_data_tdata[2*FFT_W-1:FFT_W]);
        re_sq  = fft_re * fft_re;
        im_sq  = fft_im * fft_im;
        pow    = PW'($unsigned(re_sq)) + PW'($unsigned(im_sq));
        sh_amt = 8'(POW_SH) - 8'(shiftSel);
        pow_sh = pow >> sh_amt;
        sat    = ((pow_sh >> 8) != '0) ? 8'hFF : pow_sh[7:0];
    end

`ifdef SPECTRUM_AVG_EN
    logic [7:0]        avg_mem [N];
    logic              first_q, first_d;
    logic [7:0]        avg_old;
    logic signed [8:0] avg_diff;

    // Exponential average; the first frame after reset seeds the table.
    always_comb begin
        avg_old  = avg_mem[cnt_q];
        avg_diff = $signed({1'b0, sat}) - $signed({1'b0, avg_old});
        bin_val  = first_q ? sat : avg_old + 8'(avg_diff >>> 2);
        first_d  = first_q;
        if (beat && (m_axis_data_tlast || cnt_q == CNT_LAST)) begin
            first_d = 1'b0;
        end
    end

    // Averaging RAM write port; contents are not reset.
    always_ff @(posedge ckaTime) begin
        if (beat) begin
            avg_mem[cnt_q] <= bin_val;
        end
    end

    // Seed flag for the averaging table.
    always_ff @(posedge ckaTime) begin
        if (btnL) begin
            first_q <= 1'b1;
        end else begin
            first_q <= first_d;
        end
    end
`else
    assign bin_val = sat;
`endif

    // Sample RAM write port; contents are not reset.
    always_ff @(posedge ckaTime) begin
        if (mem_we) begin
            smp_mem[mem_wa] <= smpData;
        end
    end

    // Next-state logic for the frame FSM and its datapath registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        lvl_d      = lvl_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        s_vld_d    = s_vld_q;
        s_last_d   = s_last_q;
        s_dat_d    = s_dat_q;
        fv_d       = 1'b0;
        addr_d     = addr_q;
        byte_d     = byte_q;
        err_d      = err_q;
        mem_we     = 1'b0;
        mem_wa     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (flgStartAcquisition) begin
                    state_d    = ARMED;
                    mode_d     = trigMode;
                    lvl_d      = $signed(trigLevel);
                    prev_vld_d = 1'b0;
                    err_d      = 1'b0;
                    cnt_d      = '0;
                end
            end
            ARMED: begin
                if (smpValid) begin
                    prev_d     = cur;
                    prev_vld_d = 1'b1;
                    if (trig_hit) begin
                        mem_we  = 1'b1;
                        mem_wa  = '0;
                        cnt_d   = LOG2_N'(1);
                        state_d = CAPTURE;
                    end
                end
                if (flgStartAcquisition) begin
                    mode_d = trigMode;
                    lvl_d  = $signed(trigLevel);
                end
            end
            CAPTURE: begin
                if (smpValid) begin
                    mem_we = 1'b1;
                    mem_wa = cnt_q;
                    cnt_d  = cnt_inc;
                    if (cnt_q == CNT_LAST) begin
                        state_d  = LOAD;
                        cnt_d    = '0;
                        s_vld_d  = 1'b1;
                        s_last_d = 1'b0;
                        s_dat_d  = smp_mem[0];
                    end
                end
            end
            LOAD: begin
                if (s_axis_data_tready) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d  = UNLOAD;
                        s_vld_d  = 1'b0;
                        s_last_d = 1'b0;
                        cnt_d    = '0;
                    end else begin
                        cnt_d    = cnt_inc;
                        s_dat_d  = smp_mem[cnt_inc];
                        s_last_d = (cnt_inc == CNT_LAST);
                    end
                end
            end
            UNLOAD: begin
                if (m_axis_data_tvalid) begin
                    fv_d   = 1'b1;
                    addr_d = cnt_q;
                    byte_d = bin_val;
                    cnt_d  = cnt_inc;
                    if (m_axis_data_tlast != (cnt_q == CNT_LAST)) begin
                        err_d = 1'b1;
                    end
                    if (m_axis_data_tlast || cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ckaTime) begin
        if (btnL) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mode_q     <= 2'b00;
            lvl_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            s_vld_q    <= 1'b0;
            s_last_q   <= 1'b0;
            s_dat_q    <= '0;
            fv_q       <= 1'b0;
            addr_q     <= '0;
            byte_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            lvl_q      <= lvl_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            s_vld_q    <= s_vld_d;
            s_last_q   <= s_last_d;
            s_dat_q    <= s_dat_d;
            fv_q       <= fv_d;
            addr_q     <= addr_d;
            byte_q     <= byte_d;
            err_q      <= err_d;
        end
    end

    assign s_axis_data_tdata  = {{SAMPLE_W{1'b0}}, s_dat_q};
    assign s_axis_data_tvalid = s_vld_q;
    assign s_axis_data_tlast  = s_last_q;
    assign m_axis_data_tready = (state_q == UNLOAD);
    assign addrFreq           = addr_q;
    assign byteFreqSample     = byte_q;
    assign flgFreqSampleValid = fv_q;
    assign flgBusy            = (state_q != IDLE);
    assign flgFrameErr        = err_q;

endmodule
